// File: rtl/rf_wport_arbiter.sv
// Shares the single register-file write port between WB and a small MDU result FIFO,
// with a starvation counter forcing drains. Define RF_ARB_DEBUG_EN for the debug trace ports.
module rf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_rf_we,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  input  logic [31:0] wb_pc,
  output logic        wb_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  input  logic [31:0] mdu_pc,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask
`ifdef RF_ARB_DEBUG_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_e;

  typedef struct packed {
`ifdef RF_ARB_DEBUG_EN
    logic [31:0] pc;
`endif
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         starve_q, starve_d;
  state_e                state_q, state_d;

  logic   empty, full, wb_req, force_mode, head_grant, wb_grant, push, pop;
  entry_t head;

  assign head   = mem_q[rd_ptr_q];
  assign empty  = !vld_q[rd_ptr_q];
  assign full   = vld_q[wr_ptr_q];
  assign wb_req = wb_valid & wb_rf_we;

  // In FORCE with a queued head, the head owns the port and writing WB instructions stall.
  assign force_mode = (state_q == ST_FORCE) && !empty;
  assign head_grant = !empty && (force_mode || !wb_req);
  assign wb_grant   = wb_req && !force_mode;
  assign pop        = head_grant && !reset;
  assign push       = mdu_valid && !full && !reset;

  assign mdu_ready = !full && !reset;
  assign wb_ready  = !reset && !(force_mode && wb_req);
  assign rf_waddr  = head_grant ? head.addr : wb_rf_waddr;
  assign rf_wdata  = head_grant ? head.data : wb_rf_wdata;
  assign rf_we     = !reset && (head_grant || wb_grant) && (rf_waddr != 5'd0);

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q].addr = mdu_waddr;
      mem_d[wr_ptr_q].data = mdu_wdata;
`ifdef RF_ARB_DEBUG_EN
      mem_d[wr_ptr_q].pc   = mdu_pc;
`endif
      vld_d[wr_ptr_q]      = 1'b1;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
  end

  always_comb begin
    starve_d = starve_q;
    state_d  = ST_NORMAL;
    if (empty || head_grant) begin
      starve_d = '0;
    end else if (starve_q != CW'(STARVE_LIMIT)) begin
      starve_d = starve_q + CW'(1);
    end
    // A saturated count that is still denied this cycle forces the next slot.
    if ((state_q == ST_NORMAL) && (starve_q == CW'(STARVE_LIMIT)) && !empty && !head_grant) begin
      state_d = ST_FORCE;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[i]) pend_mask[mem_q[i].addr] = 1'b1;
    end
    pend_mask[0] = 1'b0;
    if (reset) pend_mask = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      starve_q <= '0;
      state_q  <= ST_NORMAL;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      starve_q <= starve_d;
      state_q  <= state_d;
    end
    mem_q <= mem_d;
  end

`ifdef RF_ARB_DEBUG_EN
  assign debug_wb_pc       = head_grant ? head.pc : wb_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic unused_pc;
  assign unused_pc = ^{wb_pc, mdu_pc};
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter (default parameters): reset, drain, starvation,
// backpressure, r0 handling, same-address push/pop and reset with queued entries.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata, wb_pc;
  logic        wb_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata, mdu_pc;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pend_mask;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .wb_pc(wb_pc), .wb_ready(wb_ready),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .mdu_pc(mdu_pc), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic set_wb(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_valid    = v;
    wb_rf_we    = we;
    wb_rf_waddr = a;
    wb_rf_wdata = d;
    wb_pc       = 32'h1000_0000 | d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid = v;
    mdu_waddr = a;
    mdu_wdata = d;
    mdu_pc    = 32'h2000_0000 | d;
  endtask

  initial begin
    reset = 1'b1;
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    set_mdu(1'b1, 5'd9, 32'h99);

    // Reset held 3 cycles with an MDU result offered.
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("rst_rf_we", {31'b0, rf_we}, 32'd0);
      check("rst_mdu_ready", {31'b0, mdu_ready}, 32'd0);
      check("rst_wb_ready", {31'b0, wb_ready}, 32'd0);
      check("rst_pend", pend_mask, 32'd0);
    end
    tick();
    reset = 1'b0;
    set_mdu(1'b0, 5'd0, 32'h0);
    settle();
    check("post_rst_mdu_ready", {31'b0, mdu_ready}, 32'd1);
    check("post_rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("post_rst_pend", pend_mask, 32'd0);

    // Single drain into an idle WB slot.
    tick(); set_mdu(1'b1, 5'd5, 32'hAA); settle();
    check("drain_push_rf_we", {31'b0, rf_we}, 32'd0);
    check("drain_push_pend", pend_mask, 32'd0);
    tick(); set_mdu(1'b0, 5'd0, 32'h0); settle();
    check("drain_rf_we", {31'b0, rf_we}, 32'd1);
    check("drain_waddr", {27'b0, rf_waddr}, 32'd5);
    check("drain_wdata", rf_wdata, 32'hAA);
    check("drain_pend", pend_mask, 32'h20);
    tick(); settle();
    check("drain_after_pend", pend_mask, 32'd0);
    check("drain_after_rf_we", {31'b0, rf_we}, 32'd0);

    // Starvation: WB writes every cycle, r7 waits 5 cycles then is forced.
    tick(); set_wb(1'b1, 1'b1, 5'd10, 32'h1010); set_mdu(1'b1, 5'd7, 32'h77); settle();
    check("starve_push_waddr", {27'b0, rf_waddr}, 32'd10);
    for (int i = 0; i < 5; i++) begin
      tick(); set_mdu(1'b0, 5'd0, 32'h0); settle();
      check($sformatf("starve_wb_waddr_%0d", i), {27'b0, rf_waddr}, 32'd10);
      check($sformatf("starve_wb_ready_%0d", i), {31'b0, wb_ready}, 32'd1);
      check($sformatf("starve_pend_%0d", i), pend_mask, 32'h80);
    end
    tick(); settle();
    check("force_waddr", {27'b0, rf_waddr}, 32'd7);
    check("force_wdata", rf_wdata, 32'h77);
    check("force_rf_we", {31'b0, rf_we}, 32'd1);
    check("force_wb_ready", {31'b0, wb_ready}, 32'd0);
    tick(); settle();
    check("after_force_waddr", {27'b0, rf_waddr}, 32'd10);
    check("after_force_wb_ready", {31'b0, wb_ready}, 32'd1);
    check("after_force_pend", pend_mask, 32'd0);

    // Backpressure: three pushes with WB busy, FIFO holds two.
    tick(); set_mdu(1'b1, 5'd1, 32'h11); settle();
    check("bp_push1_ready", {31'b0, mdu_ready}, 32'd1);
    tick(); set_mdu(1'b1, 5'd2, 32'h22); settle();
    check("bp_push2_ready", {31'b0, mdu_ready}, 32'd1);
    tick(); set_mdu(1'b1, 5'd3, 32'h33); settle();
    check("bp_full_ready_c", {31'b0, mdu_ready}, 32'd0);
    check("bp_full_pend", pend_mask, 32'h06);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check($sformatf("bp_full_ready_%0d", i), {31'b0, mdu_ready}, 32'd0);
      check($sformatf("bp_full_waddr_%0d", i), {27'b0, rf_waddr}, 32'd10);
    end
    tick(); settle();
    check("bp_pop1_waddr", {27'b0, rf_waddr}, 32'd1);
    check("bp_pop1_wdata", rf_wdata, 32'h11);
    check("bp_pop1_wb_ready", {31'b0, wb_ready}, 32'd0);
    check("bp_pop1_mdu_ready", {31'b0, mdu_ready}, 32'd0);
    tick(); settle();
    check("bp_push3_ready", {31'b0, mdu_ready}, 32'd1);
    check("bp_push3_waddr", {27'b0, rf_waddr}, 32'd10);
    check("bp_push3_pend", pend_mask, 32'h04);
    tick(); set_mdu(1'b0, 5'd0, 32'h0); set_wb(1'b0, 1'b0, 5'd0, 32'h0); settle();
    check("bp_pop2_waddr", {27'b0, rf_waddr}, 32'd2);
    check("bp_pop2_pend", pend_mask, 32'h0C);
    tick(); settle();
    check("bp_pop3_waddr", {27'b0, rf_waddr}, 32'd3);
    check("bp_pop3_wdata", rf_wdata, 32'h33);
    check("bp_pop3_pend", pend_mask, 32'h08);
    tick(); settle();
    check("bp_empty_rf_we", {31'b0, rf_we}, 32'd0);

    // r0 result: no write, no pend bit, still popped (r4 follows right behind).
    tick(); set_mdu(1'b1, 5'd0, 32'hFFFF_FFFF); settle();
    check("r0_push_ready", {31'b0, mdu_ready}, 32'd1);
    tick(); set_mdu(1'b1, 5'd4, 32'h44); settle();
    check("r0_rf_we", {31'b0, rf_we}, 32'd0);
    check("r0_pend", pend_mask, 32'd0);
    tick(); set_mdu(1'b0, 5'd0, 32'h0); settle();
    check("r0_next_rf_we", {31'b0, rf_we}, 32'd1);
    check("r0_next_waddr", {27'b0, rf_waddr}, 32'd4);
    check("r0_next_wdata", rf_wdata, 32'h44);
    check("r0_next_pend", pend_mask, 32'h10);

    // Same-address pop and push keeps the pend bit.
    tick(); set_mdu(1'b1, 5'd6, 32'h60); settle();
    tick(); set_mdu(1'b1, 5'd6, 32'h61); settle();
    check("same_pop1_wdata", rf_wdata, 32'h60);
    check("same_pop1_pend", pend_mask, 32'h40);
    tick(); set_mdu(1'b0, 5'd0, 32'h0); settle();
    check("same_pop2_wdata", rf_wdata, 32'h61);
    check("same_pop2_pend", pend_mask, 32'h40);
    tick(); settle();
    check("same_empty_pend", pend_mask, 32'd0);

    // Reset with two entries queued discards them.
    tick(); set_wb(1'b1, 1'b1, 5'd10, 32'h1010); set_mdu(1'b1, 5'd8, 32'h88); settle();
    tick(); set_mdu(1'b1, 5'd9, 32'h99); settle();
    check("mid_q1_pend", pend_mask, 32'h100);
    tick(); set_mdu(1'b0, 5'd0, 32'h0); settle();
    check("mid_q2_pend", pend_mask, 32'h300);
    tick(); reset = 1'b1; settle();
    check("mid_rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("mid_rst_pend", pend_mask, 32'd0);
    check("mid_rst_wb_ready", {31'b0, wb_ready}, 32'd0);
    tick(); reset = 1'b0; set_wb(1'b0, 1'b0, 5'd0, 32'h0); settle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_after_rf_we_%0d", i), {31'b0, rf_we}, 32'd0);
      check($sformatf("mid_after_pend_%0d", i), pend_mask, 32'd0);
      check($sformatf("mid_after_ready_%0d", i), {31'b0, mdu_ready}, 32'd1);
      tick(); settle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
